// File: rtl/shift32_pkg.sv
// Shared definitions for the 32-bit multi-cycle shift sequencer.
// It holds the state encoding, the width constants and the direction codes.
package shift32_pkg;

    localparam int HALF_W = 16;
    localparam int AMT_W  = 5;

    localparam logic LEFT  = 1'b1;
    localparam logic RIGHT = 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        P0,
        P1,
        P2,
        DONE
    } state_t;

endpackage

// File: rtl/Shifter16_LR.sv
// 16-bit combinational logical barrel shifter with a direction select.
// Ports: din (operand), amt (0..15), lr (1=left, 0=right), dout (zero-filled result).
module Shifter16_LR (
    input  logic [15:0] din,
    input  logic [3:0]  amt,
    input  logic        lr,
    output logic [15:0] dout
);

    assign dout = lr ? (din << amt) : (din >> amt);

endmodule

// File: rtl/shift32_seq.sv
// 32-bit logical shift sequencer built on one shared 16-bit shifter.
// Ports: clk, reset_n, start/lr/amt/data_in (request), busy/done/result (status).
module shift32_seq #(
    parameter bit CLEAR_ON_START = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        lr,
    input  logic [4:0]  amt,
    input  logic [31:0] data_in,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    import shift32_pkg::*;

    state_t              state;
    logic                lr_q;
    logic [AMT_W-1:0]    amt_q;
    logic [31:0]         data_q;
    logic [HALF_W-1:0]   res_lo;
    logic [HALF_W-1:0]   res_hi;

    logic [HALF_W-1:0]   lo;
    logic [HALF_W-1:0]   hi;
    logic                left;
    logic                multi;

    logic [HALF_W-1:0]   sh_in;
    logic [3:0]          sh_amt;
    logic                sh_lr;
    logic [HALF_W-1:0]   sh_out;

    assign lo    = data_q[15:0];
    assign hi    = data_q[31:16];
    assign left  = (lr_q == LEFT);
    // Amounts 1..15 need the spill pass; 0 and 16..31 finish in one pass.
    assign multi = !amt_q[4] && (amt_q[3:0] != 4'd0);

    // P0 shifts the source half by s, P1 spills it the other way by
    // 16-s, P2 shifts the remaining half by s.
    always_comb begin
        sh_in  = left ? lo : hi;
        sh_amt = amt_q[3:0];
        sh_lr  = lr_q;
        if (state == P1) begin
            sh_amt = 4'd0 - amt_q[3:0];
            sh_lr  = left ? RIGHT : LEFT;
        end else if (state == P2) begin
            sh_in = left ? hi : lo;
        end
    end

    Shifter16_LR u_shifter (
        .din  (sh_in),
        .amt  (sh_amt),
        .lr   (sh_lr),
        .dout (sh_out)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            lr_q   <= 1'b0;
            amt_q  <= '0;
            data_q <= '0;
            res_lo <= '0;
            res_hi <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        lr_q   <= lr;
                        amt_q  <= amt;
                        data_q <= data_in;
                        busy   <= 1'b1;
                        state  <= P0;
                        if (CLEAR_ON_START) begin
                            res_lo <= '0;
                            res_hi <= '0;
                        end
                    end
                end
                P0: begin
                    if (amt_q == '0) begin
                        res_hi <= hi;
                        res_lo <= lo;
                    end else if (amt_q[4]) begin
                        // s-16 equals the low four amount bits.
                        res_hi <= left ? sh_out : '0;
                        res_lo <= left ? '0 : sh_out;
                    end else if (left) begin
                        res_lo <= sh_out;
                    end else begin
                        res_hi <= sh_out;
                    end
                    state <= multi ? P1 : DONE;
                    done  <= !multi;
                end
                P1: begin
                    if (left) res_hi <= sh_out;
                    else      res_lo <= sh_out;
                    state <= P2;
                end
                P2: begin
                    if (left) res_hi <= res_hi | sh_out;
                    else      res_lo <= res_lo | sh_out;
                    state <= DONE;
                    done  <= 1'b1;
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign result = {res_hi, res_lo};

endmodule

// File: doc/shift32_seq.md
Name: shift32_seq

Overview:
- Multi-cycle sequencer that performs 32-bit logical left/right shifts by 0..31.
- Time-multiplexes a single 16-bit combinational left/right barrel shifter (4-bit amount, lr select: 1=left, 0=right).
- Used by the execute stage for 32-bit shift ops; start/done handshake with the issuing controller.

Parameters:
- CLEAR_ON_START, 1, when 1 the result register clears to 0 on start acceptance; when 0 it keeps its old value until the first pass writes it.

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- lr  input  1  direction, 1=left, 0=right; captured on accept
- amt  input  5  shift amount 0..31; captured on accept
- data_in  input  32  operand; captured on accept
- busy  output  1  high from the accept edge until the done cycle ends
- done  output  1  one-cycle pulse; result valid
- result  output  32  shifted value, held until the next accept

Behaviour:
- Reset (async, reset_n=0): state=IDLE, busy=0, done=0, result=0, all capture regs=0. Mid-operation reset aborts with no done pulse.
- One clock edge accepts the request, then one shifter pass per cycle. Each pass result is ORed or written into the result halves at the end of its cycle.
- Notation: lo=data[15:0], hi=data[31:16], s=amt.
- IDLE, start=1: capture lr/amt/data, busy=1, go to P0.
- IDLE, start=0: stay. start while busy is ignored; there is no queueing.
- Left, s=0: single pass, result=data.
- Left, 1<=s<=15:
  - P0: res_lo = lo<<s.
  - P1: res_hi = lo>>(16-s).
  - P2: res_hi |= hi<<s.
- Left, s>=16: single pass P0, res_hi = lo<<(s-16), res_lo = 0.
- Right, s=0: single pass, result=data.
- Right, 1<=s<=15:
  - P0: res_hi = hi>>s.
  - P1: res_lo = hi<<(16-s).
  - P2: res_lo |= lo>>s.
- Right, s>=16: single pass P0, res_lo = hi>>(s-16), res_hi = 0.
- Shifter amount is always a 4-bit value:
  - 16-s is in 1..15 for s in 1..15.
  - s-16 is in 0..15 for s >= 16.
  - s=0 never uses the spill pass; this avoids the unrepresentable amount 16.
- After the last pass go to DONE. In DONE: done=1, busy=1 for exactly one cycle, then IDLE with busy=0.
- A start asserted during the DONE cycle is ignored. It is accepted on the first IDLE cycle.
- Latency, from start-accept edge to the done cycle: 3-pass ops give done high in cycle 4 (busy for 4 cycles); single-pass ops give done high in cycle 2.
- Back-to-back throughput: one op per 5 cycles (3-pass) or 3 cycles (single-pass).
- States: IDLE, P0, P1, P2, DONE. P1 and P2 are skipped when single-pass.
- Unused shifter bits are zero-filled; no sign extension, no rotation.
- result changes only on pass cycles and on accept when CLEAR_ON_START=1. It is stable from done until the next accept.

Decomposition:
- Shared package shift32_pkg:
  - state enum (IDLE, P0, P1, P2, DONE);
  - constants HALF_W=16, AMT_W=5, LEFT=1'b1, RIGHT=1'b0.
- One sub-module: instantiate the team's existing 16-bit left/right barrel shifter (Shifter16_LR). Its input, shift amount and lr are muxed per state.
- Do not replicate the shifter.

Test Plan:
- Left, data_in=0x0000_8001, amt=4 -> done 4 cycles after accept, result=0x0008_0010.
- Right, data_in=0x1234_5678, amt=8 -> result=0x0012_3456.
- Right, data_in=0x89AB_CDEF, amt=20 -> result=0x0000_089A after 2 cycles.
- Left, data_in=0x0000_ABCD, amt=16 -> result=0xABCD_0000 after 2 cycles.
- Edge amounts:
  - amt=0, any direction, data 0xDEAD_BEEF -> result=0xDEAD_BEEF.
  - Right, 0x8000_0000, amt=31 -> result=0x0000_0001.
- Handshake and reset:
  - start held high through busy -> exactly one op per accept; no done while IDLE.
  - reset_n low during P1 -> busy=0, done=0, result=0 immediately, IDLE.
